// File: rtl/mmio_sys_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mmio_sys_monitor
// Function : MMIO system monitor with a buffered STDOUT channel, a halt/exit
//            register and free-running cycle/retired-instruction counters.
//            Optional MMIO_MON_SIM_DISPLAY_EN adds simulation console output.
// Revision : 1.0
// ============================================================================
module mmio_sys_monitor #(
    parameter int                AWIDTH     = 24,
    parameter int                DWIDTH     = 32,
    parameter int                CWIDTH     = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR  = 24'hFFFFF8,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic              i_clk_en,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic              i_wr,
    input  logic              i_rd,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_sel,
    input  logic              i_instr_retire,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_halt_req,
    output logic              o_halt,
    output logic [7:0]        o_exit_code
);

    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int SW = LW + 6;

    localparam logic [2:0] c_OFF_CYCLE  = 3'd0;
    localparam logic [2:0] c_OFF_INSTR  = 3'd1;
    localparam logic [2:0] c_OFF_STATUS = 3'd2;
    localparam logic [2:0] c_OFF_STDOUT = 3'd6;
    localparam logic [2:0] c_OFF_HALT   = 3'd7;
    localparam logic [LW:0] c_FULL_LVL  = (LW+1)'(FIFO_DEPTH);

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [LW-1:0]     r_wptr, r_rptr;
    logic [LW:0]       r_level;
    logic [CWIDTH-1:0] r_cycle, r_instr;
    logic              r_ovf, r_halt_req, r_halt;
    logic [7:0]        r_exit_code;
    logic [DWIDTH-1:0] r_rdata;

    logic [2:0]        w_off;
    logic              w_wr, w_rd, w_empty, w_full, w_pop, w_push_req, w_push;
    logic              w_halt_wr, w_halt_req_nxt, w_halt_nxt;
    logic [LW:0]       w_level_nxt;
    logic [SW-1:0]     w_status;
    logic [DWIDTH-1:0] w_rdata_nxt;

    assign o_sel      = (i_addr[AWIDTH-1:3] == BASE_ADDR[AWIDTH-1:3]);
    assign w_off      = i_addr[2:0];
    assign w_wr       = i_clk_en & i_wr & o_sel;
    assign w_rd       = i_clk_en & i_rd & o_sel;
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == c_FULL_LVL);
    assign w_pop      = i_clk_en & ~w_empty & i_tx_ready;
    assign w_push_req = w_wr & (w_off == c_OFF_STDOUT);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_halt_wr  = w_wr & (w_off == c_OFF_HALT) & ~r_halt_req;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // Halt is judged on next-state values so it is visible right after the last pop.
    assign w_halt_req_nxt = r_halt_req | w_halt_wr;
    assign w_halt_nxt     = r_halt | (i_clk_en & w_halt_req_nxt & (w_level_nxt == '0));

    assign w_status = {r_level, r_ovf, r_halt, r_halt_req, w_full, w_empty};

    always_comb begin
        w_rdata_nxt = '0;
        case (w_off)
            c_OFF_CYCLE:  w_rdata_nxt = DWIDTH'(r_cycle);
            c_OFF_INSTR:  w_rdata_nxt = DWIDTH'(r_instr);
            c_OFF_STATUS: w_rdata_nxt = DWIDTH'(w_status);
            default:      w_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_cycle     <= '0;
            r_instr     <= '0;
            r_ovf       <= 1'b0;
            r_halt_req  <= 1'b0;
            r_halt      <= 1'b0;
            r_exit_code <= 8'h00;
            r_rdata     <= '0;
        end else if (i_clk_en) begin
            r_level <= w_level_nxt;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;

            if (w_wr && w_off == c_OFF_CYCLE)  r_cycle <= '0;
            else if (!r_halt_req)              r_cycle <= r_cycle + 1'b1;

            if (w_wr && w_off == c_OFF_INSTR)        r_instr <= '0;
            else if (!r_halt_req && i_instr_retire)  r_instr <= r_instr + 1'b1;

            if (w_wr && w_off == c_OFF_STATUS)  r_ovf <= 1'b0;
            else if (w_push_req && !w_push)     r_ovf <= 1'b1;

            if (w_halt_wr) begin
                r_halt_req  <= 1'b1;
                r_exit_code <= i_wdata[7:0];
            end
            r_halt <= w_halt_nxt;

            if (w_rd) r_rdata <= w_rdata_nxt;
        end
    end

    generate
        if (DWIDTH > 8) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^i_wdata[DWIDTH-1:8];
        end
    endgenerate

    assign o_rdata     = r_rdata;
    assign o_tx_valid  = ~w_empty;
    assign o_tx_data   = w_empty ? 8'h00 : r_mem[r_rptr];
    assign o_halt_req  = r_halt_req;
    assign o_halt      = r_halt;
    assign o_exit_code = r_exit_code;

`ifdef MMIO_MON_SIM_DISPLAY_EN
    always_ff @(posedge i_clk) begin
        if (i_rstb && w_pop) begin
            $write("%c", o_tx_data);
        end
        if (i_rstb && !r_halt && w_halt_nxt) begin
            $display("exit code %0d, cycles %0d, instructions %0d",
                     w_halt_wr ? i_wdata[7:0] : r_exit_code, r_cycle, r_instr);
            $finish;
        end
    end
`else
    // Synthesizable build: no console output.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmio_sys_monitor.sv
`default_nettype none
// Bench for mmio_sys_monitor: constant vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_mmio_sys_monitor;
    localparam int AW = 24, DW = 32, DEPTH = 16;
    localparam logic [AW-1:0] BASE = 24'hFFFFF8;

    logic          clk = 1'b0, rstb = 1'b0, en = 1'b0, wr = 1'b0, rd = 1'b0;
    logic          retire = 1'b0, ready = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic [7:0]    tx_data, exit_code;
    logic          sel, tx_valid, halt_req, halt;

    mmio_sys_monitor #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rstb(rstb), .i_clk_en(en), .i_addr(addr), .i_wdata(wdata),
        .i_wr(wr), .i_rd(rd), .o_rdata(rdata), .o_sel(sel), .i_instr_retire(retire),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(ready),
        .o_halt_req(halt_req), .o_halt(halt), .o_exit_code(exit_code));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Reference model state
    byte unsigned m_q[$];
    int unsigned  m_cyc, m_ins;
    bit           m_ovf, m_hreq, m_halted;
    logic [7:0]   m_exit;
    logic [31:0]  m_rdata;

    typedef struct {
        bit en, wr, rd; int off; logic [7:0] d; bit ret, rdy;
        bit exp_valid; logic [7:0] exp_data; logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int unsigned m_status();
        int unsigned n = m_q.size();
        return n * 32 + m_ovf * 16 + m_halted * 8 + m_hreq * 4 + (n == DEPTH) * 2 + (n == 0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cyc = 0; m_ins = 0; m_ovf = 0; m_hreq = 0; m_halted = 0; m_exit = 0; m_rdata = 0;
    endtask

    task automatic cmp_model();
        chk("tx_valid", tx_valid, m_q.size() != 0);
        chk("tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
        chk("halt_req", halt_req, m_hreq);
        chk("halt", halt, m_halted);
        chk("exit_code", exit_code, m_exit);
        chk("rdata", rdata, m_rdata);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit e, w, r, input int off, input logic [31:0] d, input bit ret, rdy);
        bit pop;
        en = e; wr = w; rd = r; addr = BASE + AW'(off); wdata = d; retire = ret; ready = rdy;
        if (e) begin
            pop = (m_q.size() != 0) && rdy;
            if (r) m_rdata = (off == 0) ? m_cyc : (off == 1) ? m_ins : (off == 2) ? m_status() : 0;
            if (pop) void'(m_q.pop_front());
            if (w && off == 6) begin
                if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
                else m_ovf = 1;
            end
            if (w && off == 2) m_ovf = 0;
            if (w && off == 0) m_cyc = 0; else if (!m_hreq) m_cyc++;
            if (w && off == 1) m_ins = 0; else if (!m_hreq && ret) m_ins++;
            if (w && off == 7 && !m_hreq) begin m_hreq = 1; m_exit = d[7:0]; end
            if (m_hreq && m_q.size() == 0) m_halted = 1;
        end
        @(posedge clk); #1;
        cmp_model();
        @(negedge clk);
        wr = 0; rd = 0; retire = 0;
    endtask

    task automatic do_reset();
        rstb = 0; en = 0; wr = 0; rd = 0; retire = 0; ready = 0; addr = '0;
        model_reset();
        @(posedge clk); #1;
        cmp_model();
        chk("reset_sel", sel, 1'b0);
        @(negedge clk);
        rstb = 1;
    endtask

    initial begin
        tbl[0]  = '{1,1,0,6,8'h41,0,1, 1,8'h41,32'h0};
        tbl[1]  = '{1,0,0,0,8'h00,0,1, 0,8'h00,32'h0};
        tbl[2]  = '{1,0,1,2,8'h00,0,1, 0,8'h00,32'h1};
        tbl[3]  = '{1,1,0,6,8'h42,0,0, 1,8'h42,32'h1};
        tbl[4]  = '{1,1,0,6,8'h43,0,0, 1,8'h42,32'h1};
        tbl[5]  = '{1,0,1,2,8'h00,0,0, 1,8'h42,32'h40};
        tbl[6]  = '{0,1,0,6,8'h44,0,1, 1,8'h42,32'h40};
        tbl[7]  = '{0,0,1,0,8'h00,0,0, 1,8'h42,32'h40};
        tbl[8]  = '{1,1,0,3,8'h99,0,0, 1,8'h42,32'h40};
        tbl[9]  = '{1,0,1,3,8'h00,0,0, 1,8'h42,32'h0};
        tbl[10] = '{1,0,0,0,8'h00,0,1, 1,8'h43,32'h0};
        tbl[11] = '{1,0,0,0,8'h00,0,1, 0,8'h00,32'h0};
        tbl[12] = '{1,0,1,0,8'h00,0,0, 0,8'h00,32'd10};
        tbl[13] = '{1,0,1,1,8'h00,1,0, 0,8'h00,32'h0};
        tbl[14] = '{1,0,1,1,8'h00,0,0, 0,8'h00,32'h1};
        tbl[15] = '{1,1,0,1,8'h00,1,0, 0,8'h00,32'h1};
        tbl[16] = '{1,0,1,1,8'h00,0,0, 0,8'h00,32'h0};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].en, tbl[i].wr, tbl[i].rd, tbl[i].off, {24'h0, tbl[i].d}, tbl[i].ret, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), tx_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
        end

        // Overflow, sticky clear, full push-with-pop
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 1, 0, 6, i, 0, 0);
        step(1, 0, 1, 2, 0, 0, 0);
        chk("ovf_status", rdata, 32'h212);
        step(1, 1, 0, 2, 0, 0, 0);
        step(1, 0, 1, 2, 0, 0, 0);
        chk("ovf_cleared", rdata, 32'h202);
        step(1, 1, 0, 6, 32'h55, 0, 1);
        chk("full_pushpop_head", tx_data, 8'h01);
        step(1, 0, 1, 2, 0, 0, 0);
        chk("full_pushpop_status", rdata, 32'h202);

        // Counters
        do_reset();
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 0, (i % 5) < 2, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        chk("cycle_100", rdata, 32'd100);
        step(1, 0, 1, 1, 0, 0, 0);
        chk("instr_40", rdata, 32'd40);
        step(1, 1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0);
        chk("instr_cleared", rdata, 32'd0);

        // Halt with drain
        do_reset();
        step(1, 1, 0, 6, "a", 0, 0);
        step(1, 1, 0, 6, "b", 0, 0);
        step(1, 1, 0, 6, "c", 0, 0);
        step(1, 1, 0, 7, 32'h105, 1, 0);
        chk("halt_req_set", halt_req, 1'b1);
        chk("halt_not_yet", halt, 1'b0);
        step(1, 0, 1, 0, 0, 1, 0);
        chk("cycle_frozen_a", rdata, 32'd4);
        step(1, 0, 1, 0, 0, 1, 0);
        chk("cycle_frozen_b", rdata, 32'd4);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("halt_after_pop2", halt, 1'b0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("halt_after_pop3", halt, 1'b1);
        chk("exit_code", exit_code, 8'h05);
        step(1, 1, 0, 7, 32'h09, 0, 1);
        chk("exit_first_wins", exit_code, 8'h05);

        // Clock-enable gating and asynchronous reset mid-drain
        do_reset();
        step(0, 1, 0, 6, "z", 0, 0);
        step(0, 1, 0, 7, 32'h11, 0, 0);
        chk("en_low_valid", tx_valid, 1'b0);
        chk("en_low_halt_req", halt_req, 1'b0);
        step(1, 1, 0, 6, "x", 0, 0);
        step(1, 1, 0, 6, "y", 0, 0);
        step(1, 1, 0, 7, 32'h77, 0, 0);
        step(1, 0, 1, 2, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("sel_in_window", sel, 1'b1);
        addr = BASE - 1;
        #1 chk("sel_outside", sel, 1'b0);
        #1 rstb = 0;
        #1;
        chk("arst_valid", tx_valid, 1'b0);
        chk("arst_data", tx_data, 8'h00);
        chk("arst_halt_req", halt_req, 1'b0);
        chk("arst_halt", halt, 1'b0);
        chk("arst_exit", exit_code, 8'h00);
        chk("arst_rdata", rdata, 32'h0);
        model_reset();
        @(negedge clk);
        rstb = 1;
        step(1, 0, 1, 2, 0, 0, 0);
        chk("arst_status", rdata, 32'h1);

        // Randomized traffic against the model
        for (int seg = 0; seg < 3; seg++) begin
            do_reset();
            for (int i = 0; i < 1000; i++) begin
                int off;
                off = $urandom_range(0, 7);
                if (off == 7 && $urandom_range(0, 40) != 0) off = 6;
                step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                     off, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
